// File: rtl/mem_req_bridge.sv
// Bridge between the rowhammer test state machine and the DDR controller's
// Avalon-MM local port. Turns level read/write requests into single-beat
// Avalon commands, bounds outstanding reads against a small response FIFO,
// counts issued commands and raises a sticky flag on protocol violations.
module mem_req_bridge #(
  parameter int ADDR_WIDTH     = 64,
  parameter int WORD_WIDTH     = 64,
  parameter int AVM_ADDR_WIDTH = 25,
  parameter int RSP_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cal_done,
  input  logic [ADDR_WIDTH-1:0]     req_address,
  input  logic [WORD_WIDTH-1:0]     req_wdata,
  input  logic                      req_write,
  input  logic                      req_read,
  output logic                      req_wait,
  output logic [WORD_WIDTH-1:0]     rsp_data,
  output logic                      rsp_valid,
  input  logic                      rsp_pop,
  output logic [AVM_ADDR_WIDTH-1:0] avm_address,
  output logic [WORD_WIDTH-1:0]     avm_writedata,
  output logic [WORD_WIDTH/8-1:0]   avm_byteenable,
  output logic [2:0]                avm_burstcount,
  output logic                      avm_write,
  output logic                      avm_read,
  input  logic                      avm_waitrequest,
  input  logic [WORD_WIDTH-1:0]     avm_readdata,
  input  logic                      avm_readdatavalid,
  output logic [31:0]               rd_issued,
  output logic [31:0]               wr_issued,
  output logic                      proto_err
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_WIDE = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(RSP_DEPTH);

  typedef enum logic [1:0] {
    CAL_WAIT,
    IDLE,
    ISSUE
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [WORD_WIDTH-1:0] rsp_mem [RSP_DEPTH];

  logic [CNT_W:0] in_flight;
  logic           room;
  logic           accept;
  logic           issue_done;
  logic           beat_ok;
  logic           stray_beat;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           push_drop;
  logic           pop;
  logic           pop_empty;
  logic           unused_addr;

  // Only the low address bits reach the controller; the rest are ignored.
  assign unused_addr = ^req_address;

  assign avm_byteenable = '1;
  assign avm_burstcount = 3'd1;

  // Reads already granted plus data already buffered must fit the FIFO, so a
  // read is only taken when a free slot is guaranteed for its data beat.
  assign in_flight  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign room       = in_flight < DEPTH_WIDE;
  assign accept     = (state == IDLE) && (req_write || (req_read && room));
  assign issue_done = (state == ISSUE) && !avm_waitrequest;

  assign fifo_full  = (fifo_count == DEPTH_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign beat_ok    = avm_readdatavalid && (outstanding != '0);
  assign stray_beat = avm_readdatavalid && (outstanding == '0);
  assign push       = beat_ok && !fifo_full;
  assign push_drop  = beat_ok && fifo_full;
  assign pop        = rsp_pop && !fifo_empty;
  assign pop_empty  = rsp_pop && fifo_empty;

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = rsp_mem[rd_ptr];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= CAL_WAIT;
    else       state <= state_nxt;
  end

  // Next-state and upstream back-pressure; a command in flight always
  // finishes before a calibration loss is honoured.
  always_comb begin
    state_nxt = state;
    req_wait  = 1'b1;
    case (state)
      CAL_WAIT: begin
        if (cal_done) state_nxt = IDLE;
      end
      IDLE: begin
        if (accept) begin
          req_wait  = 1'b0;
          state_nxt = ISSUE;
        end else if (!cal_done) begin
          state_nxt = CAL_WAIT;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) state_nxt = cal_done ? IDLE : CAL_WAIT;
      end
      default: state_nxt = CAL_WAIT;
    endcase
  end

  // Avalon command register: loaded on accept, held through wait states,
  // dropped after the controller takes it. Write wins over a concurrent read.
  always_ff @(posedge clk) begin
    if (reset) begin
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
    end else if (accept) begin
      avm_write     <= req_write;
      avm_read      <= !req_write;
      avm_address   <= req_address[AVM_ADDR_WIDTH-1:0];
      avm_writedata <= req_wdata;
    end else if (issue_done) begin
      avm_write <= 1'b0;
      avm_read  <= 1'b0;
    end
  end

  // Issued-command counters, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_issued <= '0;
      wr_issued <= '0;
    end else if (issue_done) begin
      if (avm_write) wr_issued <= wr_issued + 32'd1;
      else           rd_issued <= rd_issued + 32'd1;
    end
  end

  // Outstanding reads: up on a granted read, down on a matched data beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({issue_done && avm_read, beat_ok})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Response FIFO storage; contents need no reset since validity is tracked
  // by the count.
  always_ff @(posedge clk) begin
    if (push) rsp_mem[wr_ptr] <= avm_readdata;
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky protocol error: unexpected data beat, pop on empty, or overflow.
  // Beats still in flight across a reset land here by design.
  always_ff @(posedge clk) begin
    if (reset)                                    proto_err <= 1'b0;
    else if (stray_beat || pop_empty || push_drop) proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Self-checking bench for mem_req_bridge: directed scenarios followed by a
// randomized phase, all checked against a transaction-level reference model
// (command queue, response queue, outstanding count) kept in the bench.
`timescale 1ns/1ps

module tb_mem_req_bridge;
  localparam int AW    = 64;
  localparam int WW    = 64;
  localparam int AAW   = 25;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset, cal_done;
  logic [AW-1:0]  req_address;
  logic [WW-1:0]  req_wdata;
  logic           req_write, req_read, req_wait;
  logic [WW-1:0]  rsp_data;
  logic           rsp_valid, rsp_pop;
  logic [AAW-1:0] avm_address;
  logic [WW-1:0]  avm_writedata;
  logic [WW/8-1:0] avm_byteenable;
  logic [2:0]     avm_burstcount;
  logic           avm_write, avm_read, avm_waitrequest;
  logic [WW-1:0]  avm_readdata;
  logic           avm_readdatavalid;
  logic [31:0]    rd_issued, wr_issued;
  logic           proto_err;

  always #5 clk = ~clk;

  mem_req_bridge #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .AVM_ADDR_WIDTH(AAW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .cal_done(cal_done),
    .req_address(req_address), .req_wdata(req_wdata),
    .req_write(req_write), .req_read(req_read), .req_wait(req_wait),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_pop(rsp_pop),
    .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
    .avm_write(avm_write), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .rd_issued(rd_issued), .wr_issued(wr_issued), .proto_err(proto_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic           w;
    logic [AAW-1:0] addr;
    logic [WW-1:0]  data;
  } cmd_t;

  // Reference model state
  cmd_t          cmdq[$];
  logic [WW-1:0] rspq[$];
  int            pend_due[$];
  logic [WW-1:0] pend_data[$];
  int            outs = 0;
  logic          exp_perr = 1'b0;
  logic [31:0]   exp_rd = '0, exp_wr = '0;
  int            cyc_n = 0;

  // Controller / state-machine knobs and observations
  int            hold = 0, lat = 8, rd_todo = 0, wr_todo = 0;
  bit            rand_wait = 0, pop_force = 0, pop_rand = 0, stray = 0, expect_busy = 0;
  logic [WW-1:0] next_rdata = 64'h1;
  int            rd_acc = 0, wr_acc = 0, req_low = 0, wr_cmd_cycles = 0, rd_cmd_cycles = 0;
  logic [WW-1:0] popped[$];
  logic          hs_type[$];

  // One clock cycle: drive controller/pop inputs at negedge, check, then
  // advance the model across the rising edge.
  task automatic cyc();
    logic cmd, hs, acc, rdv_now, rdv_ok, rst_now, pop_now, stray_now;
    cmd_t acc_e;
    logic [WW-1:0] rdv_data;
    int pre_size, due;
    @(negedge clk);
    cmd = avm_read | avm_write;
    if (cmd && hold > 0) begin
      avm_waitrequest = 1'b1;
      hold--;
    end else if (cmd && rand_wait) avm_waitrequest = ($urandom_range(0, 2) == 0);
    else avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    if (stray) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = {$urandom, $urandom};
    end else if (pend_due.size() != 0 && pend_due[0] <= cyc_n) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = pend_data[0];
    end
    rsp_pop = pop_force | (pop_rand & ($urandom_range(0, 1) == 1));
    #1;
    rst_now   = reset;
    stray_now = stray;
    acc       = !req_wait && (req_write || req_read);
    acc_e     = '{req_write, req_address[AAW-1:0], req_wdata};
    hs        = cmd && !avm_waitrequest;
    rdv_now   = avm_readdatavalid;
    rdv_data  = avm_readdata;
    rdv_ok    = rdv_now && (outs > 0);
    pop_now   = rsp_pop;
    pre_size  = rspq.size();
    if (!rst_now) begin
      if (avm_write) wr_cmd_cycles++;
      if (avm_read)  rd_cmd_cycles++;
      if (acc)       req_low++;
      chk("rsp_valid", rsp_valid, (rspq.size() != 0));
      if (rspq.size() != 0) chk("rsp_data", rsp_data, rspq[0]);
      chk("proto_err", proto_err, exp_perr);
      chk("rd_issued", rd_issued, exp_rd);
      chk("wr_issued", wr_issued, exp_wr);
      chk("cmd_active", cmd, (cmdq.size() != 0));
      chk("byteenable", avm_byteenable, 8'hFF);
      chk("burstcount", avm_burstcount, 3'd1);
      if (cmdq.size() != 0) begin
        chk("cmd_is_write", avm_write, cmdq[0].w);
        chk("cmd_is_read", avm_read, !cmdq[0].w);
        chk("avm_address", avm_address, cmdq[0].addr);
        if (cmdq[0].w) chk("avm_writedata", avm_writedata, cmdq[0].data);
        chk("req_wait_while_issuing", req_wait, 1'b1);
      end
      if (expect_busy) chk("req_wait_not_ready", req_wait, 1'b1);
      if (acc && !req_write) chk("read_room", ((outs + rspq.size()) < DEPTH), 1'b1);
    end
    @(posedge clk);
    #1;
    if (rst_now) begin
      cmdq.delete(); rspq.delete(); pend_due.delete(); pend_data.delete();
      outs = 0; exp_perr = 1'b0; exp_rd = '0; exp_wr = '0; hold = 0;
    end else begin
      if (hs && cmdq.size() != 0) begin
        hs_type.push_back(cmdq[0].w);
        if (cmdq[0].w) exp_wr++;
        else begin
          exp_rd++;
          outs++;
          due = cyc_n + lat;
          if (pend_due.size() != 0 && due <= pend_due[$]) due = pend_due[$] + 1;
          pend_due.push_back(due);
          pend_data.push_back(next_rdata);
          next_rdata++;
        end
        void'(cmdq.pop_front());
      end
      if (acc) begin
        cmdq.push_back(acc_e);
        if (acc_e.w) begin
          wr_acc++;
          if (wr_todo > 0) begin
            wr_todo--;
            req_address = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
          end else req_write = 1'b0;
        end else begin
          rd_acc++;
          if (rd_todo > 0) begin
            rd_todo--;
            req_address = {$urandom, $urandom};
          end else req_read = 1'b0;
        end
      end
      if (pop_now) begin
        if (pre_size > 0) popped.push_back(rspq.pop_front());
        else exp_perr = 1'b1;
      end
      if (rdv_ok) begin
        outs--;
        if (!stray_now && pend_due.size() != 0) begin
          void'(pend_due.pop_front());
          void'(pend_data.pop_front());
        end
        if (pre_size >= DEPTH) exp_perr = 1'b1;
        else rspq.push_back(rdv_data);
      end else if (rdv_now) exp_perr = 1'b1;
    end
    cyc_n++;
  endtask

  task automatic run_until_idle(input int bound);
    int n = 0;
    while ((req_write || req_read || cmdq.size() != 0) && n < bound) begin
      cyc();
      n++;
    end
    chk("idle_within_bound", (req_write || req_read || cmdq.size() != 0), 1'b0);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    pop_force = 1'b1;
    while ((req_write || req_read || cmdq.size() != 0 || outs != 0 || rspq.size() != 0)
           && n < bound) begin
      cyc();
      n++;
    end
    pop_force = 1'b0;
    chk("drained_within_bound", (outs + rspq.size() + cmdq.size()), 0);
  endtask

  initial begin
    int base_r, base_w, guard;
    logic [31:0] issued_r, issued_w;
    reset = 1'b1; cal_done = 1'b0; req_address = '0; req_wdata = '0;
    req_write = 1'b0; req_read = 1'b0; rsp_pop = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    chk("reset_req_wait", req_wait, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_avm_write", avm_write, 1'b0);
    chk("reset_avm_read", avm_read, 1'b0);
    chk("reset_avm_address", avm_address, 25'h0);
    chk("reset_avm_writedata", avm_writedata, 64'h0);
    chk("reset_rd_issued", rd_issued, 32'h0);
    chk("reset_wr_issued", wr_issued, 32'h0);
    chk("reset_proto_err", proto_err, 1'b0);

    // Single write after calibration; the request is already up during CAL_WAIT.
    req_write = 1'b1; req_address = 64'h40; req_wdata = 64'hA5A5A5A5A5A5A5A5;
    expect_busy = 1'b1;
    repeat (10) cyc();
    expect_busy = 1'b0;
    cal_done = 1'b1;
    req_low = 0; wr_cmd_cycles = 0;
    run_until_idle(20);
    cyc();
    n_assert++;
    if (req_low != 1) begin
      n_fail++;
      $error("FAIL t1_req_wait_low_cycles: observed %0d expected 1", req_low);
    end
    n_assert++;
    if (wr_cmd_cycles != 1) begin
      n_fail++;
      $error("FAIL t1_avm_write_cycles: observed %0d expected 1", wr_cmd_cycles);
    end
    n_assert++;
    if (wr_issued !== 32'd1) begin
      n_fail++;
      $error("FAIL t1_wr_issued: observed %0d expected 1", wr_issued);
    end

    // Read held off by waitrequest for 5 cycles.
    req_read = 1'b1; req_address = {$urandom, $urandom}; hold = 5;
    req_low = 0; rd_cmd_cycles = 0;
    run_until_idle(30);
    chk("t2_avm_read_cycles", rd_cmd_cycles, 6);
    chk("t2_req_accepts", req_low, 1);
    chk("t2_rd_issued", rd_issued, 32'd1);
    drain(40);

    // Six back-to-back reads, 8-cycle latency, nothing popped.
    popped.delete(); next_rdata = 64'h1; lat = 8; base_r = rd_acc;
    req_read = 1'b1; req_address = {$urandom, $urandom}; rd_todo = 5;
    repeat (40) cyc();
    chk("t3_reads_accepted", (rd_acc - base_r), 4);
    chk("t3_req_wait_full", req_wait, 1'b1);
    chk("t3_fifo_valid", rsp_valid, 1'b1);
    drain(150);
    chk("t3_popped_count", popped.size(), 6);
    for (int i = 0; i < 6 && i < popped.size(); i++) begin
      n_assert++;
      if (popped[i] !== 64'(i + 1)) begin
        n_fail++;
        $error("FAIL t3_pop_order[%0d]: observed 'h%0h expected 'h%0h", i, popped[i], i + 1);
      end
    end

    // Short latency so data beats coincide with read grants, pops overlap pushes.
    popped.delete(); next_rdata = 64'h100; lat = 2;
    req_read = 1'b1; req_address = {$urandom, $urandom}; rd_todo = 5;
    repeat (6) cyc();
    drain(150);
    chk("t4_popped_count", popped.size(), 6);
    for (int i = 0; i < 6 && i < popped.size(); i++) begin
      n_assert++;
      if (popped[i] !== 64'h100 + 64'(i)) begin
        n_fail++;
        $error("FAIL t4_pop_order[%0d]: observed 'h%0h expected 'h%0h", i, popped[i], 64'h100 + 64'(i));
      end
    end

    // Concurrent write and read requests: write goes first.
    hs_type.delete(); issued_r = rd_issued; issued_w = wr_issued;
    req_write = 1'b1; req_read = 1'b1; req_address = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom}; lat = 3;
    run_until_idle(30);
    drain(40);
    chk("t5_handshakes", hs_type.size(), 2);
    if (hs_type.size() == 2) begin
      chk("t5_first_is_write", hs_type[0], 1'b1);
      chk("t5_second_is_read", hs_type[1], 1'b0);
    end
    n_assert++;
    if (wr_issued !== issued_w + 32'd1) begin
      n_fail++;
      $error("FAIL t5_wr_delta: observed %0d expected %0d", wr_issued, issued_w + 32'd1);
    end
    n_assert++;
    if (rd_issued !== issued_r + 32'd1) begin
      n_fail++;
      $error("FAIL t5_rd_delta: observed %0d expected %0d", rd_issued, issued_r + 32'd1);
    end

    // Calibration lost mid-command: command completes, then no new accepts.
    base_w = wr_acc;
    req_write = 1'b1; req_address = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    hold = 3;
    cyc();
    cal_done = 1'b0;
    guard = 0;
    while (cmdq.size() != 0 && guard < 20) begin cyc(); guard++; end
    chk("t6_cmd_completed", cmdq.size(), 0);
    req_write = 1'b1; req_address = {$urandom, $urandom};
    expect_busy = 1'b1;
    repeat (5) cyc();
    expect_busy = 1'b0;
    n_assert++;
    if (wr_acc != base_w + 1) begin
      n_fail++;
      $error("FAIL t6_no_accept_uncal: observed %0d expected %0d", wr_acc, base_w + 1);
    end
    cal_done = 1'b1;
    run_until_idle(20);

    // Randomized traffic with random waitrequest, latency and pops.
    rand_wait = 1'b1; pop_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!req_write && !req_read) begin
        case ($urandom_range(0, 3))
          0:       req_write = 1'b1;
          1, 2:    req_read = 1'b1;
          default: begin req_write = 1'b1; req_read = 1'b1; end
        endcase
        req_address = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
      end
      lat = $urandom_range(1, 10);
      cyc();
    end
    rand_wait = 1'b0; pop_rand = 1'b0;
    drain(300);

    // Stray data beat after reset, then pop on empty; both set the sticky flag.
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    chk("t7_perr_cleared", proto_err, 1'b0);
    stray = 1'b1;
    cyc();
    stray = 1'b0;
    repeat (3) cyc();
    n_assert++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $error("FAIL t7_perr_stray: observed %b expected 1", proto_err);
    end
    chk("t7_fifo_empty", rsp_valid, 1'b0);
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    pop_force = 1'b1;
    cyc();
    pop_force = 1'b0;
    repeat (4) cyc();
    n_assert++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $error("FAIL t7_perr_pop_empty: observed %b expected 1", proto_err);
    end
    n_assert++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $error("FAIL t7_fifo_still_empty: observed %b expected 0", rsp_valid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_req_bridge.md
Name: mem_req_bridge

Overview:
- Sits directly downstream of the rowhammer test state machine and upstream of the Stratix V DDR controller's Avalon-MM local port.
- Converts the state machine's level read/write requests into Avalon-MM single-beat commands and returns wait_request-style back-pressure.
- Buffers returned read data in a small response FIFO and presents it to the state machine as pattern_rb/read_data_valid.
- Bounds outstanding reads so the response FIFO can never overflow; counts issued commands and flags protocol errors.

Parameters:
ADDR_WIDTH, 64, upstream address width (bits)
WORD_WIDTH, 64, data word width (bits); must be a multiple of 8
AVM_ADDR_WIDTH, 25, Avalon local address width; low bits of the upstream address are used
RSP_DEPTH, 4, response FIFO depth; power of 2, at least 2

Ports:
clk  in  1  controller local clock (afi_half_clk domain)
reset  in  1  synchronous, active-high
cal_done  in  1  controller calibration/init complete
req_address  in  ADDR_WIDTH  request address from test SM
req_wdata  in  WORD_WIDTH  write data from test SM
req_write  in  1  write request, held until accepted
req_read  in  1  read request, held until accepted
req_wait  out  1  back-pressure to SM; low = request accepted this cycle
rsp_data  out  WORD_WIDTH  head of response FIFO (pattern_rb)
rsp_valid  out  1  response FIFO non-empty (read_data_valid)
rsp_pop  in  1  consume head entry; ignored when rsp_valid=0
avm_address  out  AVM_ADDR_WIDTH  Avalon address
avm_writedata  out  WORD_WIDTH  Avalon write data
avm_byteenable  out  WORD_WIDTH/8  constant all-ones
avm_burstcount  out  3  constant 1
avm_write  out  1  Avalon write command
avm_read  out  1  Avalon read command
avm_waitrequest  in  1  Avalon stall
avm_readdata  in  WORD_WIDTH  Avalon read data
avm_readdatavalid  in  1  Avalon read data strobe
rd_issued  out  32  reads accepted by the controller
wr_issued  out  32  writes accepted by the controller
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: avm_read, avm_write = 0; avm_address, avm_writedata = 0; req_wait = 1; rsp_valid = 0; rd_issued, wr_issued = 0; proto_err = 0; outstanding = 0; FIFO empty.
- FSM states:
  - CAL_WAIT: entered from reset; go to IDLE when cal_done = 1.
  - IDLE: accept condition is (req_write | (req_read & room)).
  - ISSUE: hold the Avalon command.
- room = (outstanding + fifo_count) < RSP_DEPTH. Both counters are log2(RSP_DEPTH)+1 bits.
- req_wait is combinational: low only when state = IDLE and the accept condition holds; high in all other states.
- Accept in cycle N:
  - Register address[AVM_ADDR_WIDTH-1:0], wdata and command type.
  - In cycle N+1, assert avm_write or avm_read and enter ISSUE.
- Simultaneous req_write and req_read: write wins. The read stays pending (held upstream) and is accepted on a later IDLE cycle.
- ISSUE:
  - Command and address/data stay stable while avm_waitrequest = 1.
  - On the first cycle with avm_waitrequest = 0: deassert the command next cycle, return to IDLE, and increment wr_issued or rd_issued (wrapping modulo 2^32).
  - A read increments outstanding in that cycle.
  - Minimum request-to-request period is 2 cycles.
- cal_done falling while in IDLE returns to CAL_WAIT. In ISSUE, the command completes first, then the FSM goes to CAL_WAIT.
- avm_readdatavalid with outstanding > 0: push avm_readdata into the FIFO and decrement outstanding. rsp_valid rises the following cycle (1-cycle registered latency).
- avm_readdatavalid with outstanding = 0: discard the data and set proto_err.
- Read accept and readdatavalid in the same cycle: outstanding is unchanged.
- FIFO:
  - rsp_data shows the head entry.
  - Push and pop in the same cycle: fifo_count is unchanged and data order is preserved.
  - Pop on empty: ignored, sets proto_err.
  - Push when full cannot occur by construction; if it does, drop the data and set proto_err.
- proto_err clears only on reset.
- Reset mid-transaction: all state is cleared immediately. Late readdatavalid beats after reset hit outstanding = 0 and set proto_err; this is acceptable and documented.

Test Plan:
- Reset, then cal_done high after 10 cycles, then req_write addr 0x40, data 0xA5A5A5A5A5A5A5A5, avm_waitrequest=0 -> req_wait low for 1 cycle; avm_write high exactly 1 cycle with avm_address 0x40 and correct data; wr_issued = 1.
- req_read with avm_waitrequest held high 5 cycles -> avm_read and address held stable for 6 cycles; rd_issued increments once; req_wait stays high throughout.
- 6 back-to-back reads, controller returns data 0x1..0x6 after 8 cycles, rsp_pop=0 -> only 4 reads accepted; req_wait stays high until pops occur; after popping, data emerges in order 0x1..0x6.
- readdatavalid with read accept in the same cycle, and push with pop in the same cycle -> outstanding and fifo_count unchanged; no data lost.
- req_write and req_read both high -> write issued first, read issued next; wr_issued = 1, rd_issued = 1.
- Stray avm_readdatavalid after reset, and rsp_pop while empty -> proto_err = 1 and sticky; FIFO stays empty.
